// File: rtl/serial_negate_ctrl.sv
// Word-level sequencer for a shared bit-serial two's-complementer: accepts an operand,
// clears the complementer, streams the operand LSB first and reassembles the negated result.
module serial_negate_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SER_LAT = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ser_i,
  output logic             ser_r,
  input  logic             ser_y
);

  localparam int unsigned CntW = $clog2(WIDTH + SER_LAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH + SER_LAT - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             sample;

  // With a registered complementer the first shift cycle still shows the cleared output.
  assign sample = (SER_LAT == 0) || (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opnd_d  = in_data;
          ovf_d   = (in_data == MinVal);
          state_d = StClr;
        end
      end
      StClr: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // Zeros shifted in at the top make the drain cycle drive ser_i=0.
        opnd_d = opnd_q >> 1;
        if (sample) begin
          res_d = {ser_y, res_q[WIDTH-1:1]};
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = valid_q;
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;
  assign ser_i     = (state_q == StShift) & opnd_q[0];
  assign ser_r     = r | (state_q == StClr);

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Bench for serial_negate_ctrl: one instance per complementer latency, each paired with a
// behavioural complementer and a cycle-level expectation model of the word protocol.
module tb_serial_negate_ctrl;

  localparam int W = 8;
  localparam int LAT [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         r         [2];
  logic         in_valid  [2];
  logic         out_ready [2];
  logic [W-1:0] in_data   [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ovf   [2];
  logic         ser_i     [2];
  logic         ser_r     [2];
  logic         ser_y     [2];
  logic [W-1:0] out_data  [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  serial_negate_ctrl #(.WIDTH(W), .SER_LAT(0)) u_dut0 (
    .clk(clk), .r(r[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_ovf(out_ovf[0]), .ser_i(ser_i[0]), .ser_r(ser_r[0]),
    .ser_y(ser_y[0])
  );

  serial_negate_ctrl #(.WIDTH(W), .SER_LAT(1)) u_dut1 (
    .clk(clk), .r(r[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_ovf(out_ovf[1]), .ser_i(ser_i[1]), .ser_r(ser_r[1]),
    .ser_y(ser_y[1])
  );

  // Serial two's complementer: copy bits up to and including the first 1, invert after.
  logic seen [2] = '{1'b0, 1'b0};
  logic yq   [2] = '{1'b0, 1'b0};
  assign ser_y[0] = ser_i[0] ^ seen[0];
  assign ser_y[1] = yq[1];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ser_r[g]) begin
        seen[g] <= 1'b0;
        yq[g]   <= 1'b0;
      end else begin
        yq[g]   <= ser_i[g] ^ seen[g];
        seen[g] <= seen[g] | ser_i[g];
      end
    end
  end

  // Protocol model: since = cycles elapsed since accept (1 = clear cycle), -1 when none in flight.
  int           since   [2] = '{-1, -1};
  logic         done    [2] = '{1'b0, 1'b0};
  logic [W-1:0] cur_op  [2];
  logic [W-1:0] exp_res [2];
  logic         exp_ovf [2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (r[g]) begin
        since[g]   <= -1;
        done[g]    <= 1'b0;
        exp_res[g] <= '0;
        exp_ovf[g] <= 1'b0;
      end else if (done[g]) begin
        if (out_ready[g]) done[g] <= 1'b0;
      end else if (since[g] >= 0) begin
        if (since[g] == W + LAT[g] + 1) begin
          since[g]   <= -1;
          done[g]    <= 1'b1;
          exp_res[g] <= W'(-cur_op[g]);
          exp_ovf[g] <= (cur_op[g] == 8'h80);
        end else begin
          since[g] <= since[g] + 1;
        end
      end else if (in_valid[g]) begin
        since[g]  <= 1;
        cur_op[g] <= in_data[g];
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, want %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        logic exp_si;
        exp_si = (since[g] >= 2 && since[g] <= W + 1) ? cur_op[g][since[g] - 2] : 1'b0;
        check("in_ready", g, in_ready[g], (since[g] < 0) && !done[g]);
        check("out_valid", g, out_valid[g], done[g]);
        check("ser_r", g, ser_r[g], r[g] | (since[g] == 1));
        check("ser_i", g, ser_i[g], exp_si);
        if (done[g]) begin
          check("out_data", g, out_data[g], exp_res[g]);
          check("out_ovf", g, out_ovf[g], exp_ovf[g]);
        end
      end
    end
  end

  // Entered #1 after the accepting edge; edges counts that edge as 1.
  task automatic run_to_valid(input int g, output int edges, output int rp,
                              output logic [W-1:0] bits, output bit ok);
    edges = 1;
    rp    = 0;
    bits  = '0;
    ok    = 1'b0;
    while (!ok && edges < 40) begin
      @(negedge clk);
      if (ser_r[g]) rp++;
      if (edges >= 2 && edges <= W + 1) bits[edges-2] = ser_i[g];
      if (out_valid[g]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check("valid within bound", g, ok, 1'b1);
  endtask

  task automatic send(input int g, input logic [W-1:0] d, input logic [W-1:0] er,
                      input logic eo, input int elat, input string nm);
    int edges, rp;
    logic [W-1:0] bits;
    bit ok;
    in_valid[g]  = 1'b1;
    in_data[g]   = d;
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_data[g]  = ~d;
    run_to_valid(g, edges, rp, bits, ok);
    check({nm, " out_data"}, g, out_data[g], er);
    check({nm, " out_ovf"}, g, out_ovf[g], eo);
    check({nm, " latency"}, g, W'(edges), W'(elat));
    check({nm, " ser_r pulses"}, g, W'(rp), 8'd1);
    check({nm, " ser_i stream"}, g, bits, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges, rp;
    logic [W-1:0] bits;
    bit ok, vseen;
    r         = '{1'b1, 1'b1};
    in_valid  = '{1'b0, 1'b0};
    out_ready = '{1'b0, 1'b0};
    in_data   = '{8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    r      = '{1'b0, 1'b0};
    chk_en = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset out_valid", g, out_valid[g], 1'b0);
      check("reset out_data", g, out_data[g], 8'h00);
      check("reset out_ovf", g, out_ovf[g], 1'b0);
      check("reset in_ready", g, in_ready[g], 1'b1);
      check("reset ser_i", g, ser_i[g], 1'b0);
    end
    @(posedge clk);
    #1;

    send(0, 8'h05, 8'hFB, 1'b0, 10, "w05");
    send(0, 8'h00, 8'h00, 1'b0, 10, "w00");
    send(0, 8'h01, 8'hFF, 1'b0, 10, "w01");
    send(0, 8'h7F, 8'h81, 1'b0, 10, "w7F");
    send(0, 8'h80, 8'h80, 1'b1, 10, "w80");

    // Back-pressure: second word waits in_valid-high until the first is taken.
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h12;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    in_data[0] = 8'h34;
    run_to_valid(0, edges, rp, bits, ok);
    check("bp first data", 0, out_data[0], 8'hEE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp hold valid", 0, out_valid[0], 1'b1);
      check("bp hold data", 0, out_data[0], 8'hEE);
      check("bp in_ready low", 0, in_ready[0], 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    run_to_valid(0, edges, rp, bits, ok);
    check("bp second data", 0, out_data[0], 8'hCC);
    check("bp second latency", 0, W'(edges), 8'd10);
    @(posedge clk);
    #1;

    // Abort during SHIFT bit 3 of 8'h33.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h33;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    r[0] = 1'b1;
    @(posedge clk);
    #1;
    r[0] = 1'b0;
    @(negedge clk);
    check("abort in_ready", 0, in_ready[0], 1'b1);
    check("abort out_valid", 0, out_valid[0], 1'b0);
    vseen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0]) vseen = 1'b1;
    end
    check("abort no result", 0, vseen, 1'b0);
    @(posedge clk);
    #1;
    send(0, 8'h02, 8'hFE, 1'b0, 10, "w02 after abort");

    send(1, 8'h05, 8'hFB, 1'b0, 11, "lat1 w05");
    send(1, 8'h80, 8'h80, 1'b1, 11, "lat1 w80");
    send(1, 8'h7F, 8'h81, 1'b0, 11, "lat1 w7F");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
